// File: rtl/var_snapshot_reader_if.sv
// Byte-stream and array-read bus between the snapshot reader, the
// variable storage (array side) and the downstream byte sink.
interface var_snapshot_reader_if;
  // Stream towards the sink
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  // Array read port towards the storage
  logic       arr_rd_en;
  logic [3:0] arr_addr;
  logic [7:0] arr_rdata;

  // Reader side: drives the stream and the array read strobe/address
  modport master (
    output out_data,
    output out_valid,
    output out_last,
    output arr_rd_en,
    output arr_addr,
    input  out_ready,
    input  arr_rdata
  );

  // Sink/storage side
  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    input  arr_rd_en,
    input  arr_addr,
    output out_ready,
    output arr_rdata
  );
endinterface

// File: rtl/var_snapshot_reader.sv
// Snapshot reader: captures the scalar variables on request, reads the byte
// array one entry at a time and streams everything out as a framed byte
// stream terminated by an XOR checksum byte.
module var_snapshot_reader #(
  parameter int         ARRAY_DEPTH = 10,
  parameter logic [7:0] HEADER      = 8'hA5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   snap_req,
  input  logic                   in_bit,
  input  logic [15:0]            in_16,
  input  logic [31:0]            in_32,
  input  logic [63:0]            in_64,
  var_snapshot_reader_if.master  bus,
  output logic                   busy,
  output logic                   overrun
);

  localparam logic [3:0] LAST_ADDR   = 4'(ARRAY_DEPTH - 1);
  localparam logic [3:0] LAST_SCALAR = 4'd14;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    SCALAR,
    ARR_RD,
    ARR_SEND,
    CSUM
  } state_t;

  state_t       state_q, state_d;
  // 15 scalar bytes, MSB-first; the byte on the wire is always the top one
  logic [119:0] cap_q, cap_d;
  logic [3:0]   idx_q, idx_d;
  logic [3:0]   addr_q, addr_d;
  logic [7:0]   csum_q, csum_d;
  logic [7:0]   arr_q, arr_d;
  // Set once arr_rdata has been latched for the current array byte
  logic         hold_q, hold_d;
  logic         overrun_q, overrun_d;

  logic [7:0]   out_data_c;
  logic         out_valid_c;
  logic         out_last_c;
  logic         rd_en_c;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: captured scalars, counters, checksum, array byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_q     <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      csum_q    <= '0;
      arr_q     <= '0;
      hold_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cap_q     <= cap_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      csum_q    <= csum_d;
      arr_q     <= arr_d;
      hold_q    <= hold_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state, datapath updates and stream outputs
  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    csum_d      = csum_q;
    arr_d       = arr_q;
    hold_d      = hold_q;
    overrun_d   = overrun_q;
    out_data_c  = 8'h00;
    out_valid_c = 1'b0;
    out_last_c  = 1'b0;
    rd_en_c     = 1'b0;

    // A request that cannot be honoured is only remembered, never queued;
    // this includes the cycle on which the checksum byte is accepted.
    if (snap_req && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (snap_req) begin
          state_d = HDR;
          cap_d   = {7'b0, in_bit, in_16, in_32, in_64};
          idx_d   = '0;
          addr_d  = '0;
          csum_d  = '0;
        end
      end

      HDR: begin
        out_valid_c = 1'b1;
        out_data_c  = HEADER;
        if (bus.out_ready) begin
          csum_d  = csum_q ^ out_data_c;
          state_d = SCALAR;
        end
      end

      SCALAR: begin
        out_valid_c = 1'b1;
        out_data_c  = cap_q[119:112];
        if (bus.out_ready) begin
          csum_d = csum_q ^ out_data_c;
          cap_d  = {cap_q[111:0], 8'h00};
          if (idx_q == LAST_SCALAR) begin
            state_d = ARR_RD;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      ARR_RD: begin
        rd_en_c = 1'b1;
        hold_d  = 1'b0;
        state_d = ARR_SEND;
      end

      ARR_SEND: begin
        // Read data is only valid in the first cycle here, so it is passed
        // straight through then and replayed from arr_q while stalled.
        out_valid_c = 1'b1;
        out_data_c  = hold_q ? arr_q : bus.arr_rdata;
        if (!hold_q) begin
          arr_d  = bus.arr_rdata;
          hold_d = 1'b1;
        end
        if (bus.out_ready) begin
          csum_d = csum_q ^ out_data_c;
          if (addr_q == LAST_ADDR) begin
            state_d = CSUM;
          end else begin
            addr_d  = addr_q + 4'd1;
            state_d = ARR_RD;
          end
        end
      end

      CSUM: begin
        out_valid_c = 1'b1;
        out_data_c  = csum_q;
        out_last_c  = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.out_data  = out_data_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_last  = out_last_c;
  assign bus.arr_rd_en = rd_en_c;
  assign bus.arr_addr  = addr_q;
  assign busy          = (state_q != IDLE);
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_var_snapshot_reader.sv
// Bench for var_snapshot_reader: directed frames plus randomized frames,
// each compared with a byte-list model of the frame format.
module tb_var_snapshot_reader;
  localparam int D = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        snap_req = 1'b0;
  logic        in_bit = 1'b0;
  logic [15:0] in_16 = '0;
  logic [31:0] in_32 = '0;
  logic [63:0] in_64 = '0;
  logic        busy;
  logic        overrun;

  var_snapshot_reader_if bus();

  var_snapshot_reader #(.ARRAY_DEPTH(D), .HEADER(8'hA5)) dut (
    .clk      (clk),
    .reset    (reset),
    .snap_req (snap_req),
    .in_bit   (in_bit),
    .in_16    (in_16),
    .in_32    (in_32),
    .in_64    (in_64),
    .bus      (bus),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Array storage with a one-cycle registered read; garbage otherwise
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (bus.arr_rd_en) bus.arr_rdata <= mem[bus.arr_addr];
    else               bus.arr_rdata <= 8'($urandom);
  end

  // Received stream
  logic [7:0] rx_data [$];
  bit         rx_last [$];
  logic [3:0] rd_addr [$];
  logic [7:0] exp_q   [$];

  // Sink ready pattern: 0 always, 1 toggle, 2 random, 3 toggle + stall on byte 3
  int ready_mode = 0;
  int stall_cnt  = 0;
  bit stall_used = 0;
  always @(posedge clk) begin
    #1;
    if (ready_mode != 3) stall_used = 0;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1, 3:    bus.out_ready = (bus.out_ready === 1'b1) ? 1'b0 : 1'b1;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
    if (ready_mode == 3 && !stall_used && rx_data.size() == 3) begin
      stall_used = 1;
      stall_cnt  = 5;
    end
    if (stall_cnt > 0) begin
      bus.out_ready = 1'b0;
      stall_cnt--;
    end
  end

  // Monitor: record handshakes, read strobes, and check hold-while-stalled
  bit         prev_pend = 0;
  logic [7:0] prev_data;
  logic       prev_lastv;
  always @(negedge clk) begin
    if (reset) begin
      prev_pend = 0;
    end else begin
      if (prev_pend) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_data", bus.out_data, prev_data);
        chk("hold_last", bus.out_last, prev_lastv);
      end
      if (bus.arr_rd_en) rd_addr.push_back(bus.arr_addr);
      if (bus.out_valid && bus.out_ready) begin
        rx_data.push_back(bus.out_data);
        rx_last.push_back(bus.out_last);
      end
      prev_pend  = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_lastv = bus.out_last;
    end
  end

  // Frame model: header, bit byte, scalars MSB first, array, XOR of all
  task automatic build_expected();
    logic [7:0] x;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back({7'b0, in_bit});
    for (int i = 1; i >= 0; i--) exp_q.push_back(8'(in_16 >> (8 * i)));
    for (int i = 3; i >= 0; i--) exp_q.push_back(8'(in_32 >> (8 * i)));
    for (int i = 7; i >= 0; i--) exp_q.push_back(8'(in_64 >> (8 * i)));
    for (int i = 0; i < D; i++) exp_q.push_back(mem[i]);
    x = 8'h00;
    foreach (exp_q[i]) x = x ^ exp_q[i];
    exp_q.push_back(x);
  endtask

  task automatic clear_rx();
    rx_data.delete();
    rx_last.delete();
    rd_addr.delete();
  endtask

  task automatic start_frame();
    @(posedge clk); #1;
    clear_rx();
    snap_req = 1'b1;
    @(posedge clk); #1;
    snap_req = 1'b0;
  endtask

  task automatic wait_rx(input string tag, input int n);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if (rx_data.size() >= n) break;
    end
    chk({tag, "_timeout"}, rx_data.size() >= n, 1);
  endtask

  task automatic check_frame(input string tag);
    int n;
    n = exp_q.size();
    wait_rx(tag, n);
    chk({tag, "_busy_in"}, busy, 1);
    @(negedge clk); #1;
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_len"}, rx_data.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < rx_data.size()) begin
        chk($sformatf("%s_byte%0d", tag, i), rx_data[i], exp_q[i]);
        chk($sformatf("%s_last%0d", tag, i), rx_last[i], (i == n - 1));
      end
    end
    chk({tag, "_rd_pulses"}, rd_addr.size(), D);
    for (int i = 0; i < D; i++) begin
      if (i < rd_addr.size()) chk($sformatf("%s_rd_addr%0d", tag, i), rd_addr[i], i);
    end
    chk({tag, "_addr_hold"}, bus.arr_addr, D - 1);
    $display("frame %s: %0d bytes received, checksum %0h", tag, rx_data.size(),
             (rx_data.size() > 0) ? rx_data[rx_data.size() - 1] : 8'h00);
  endtask

  task automatic set_reference();
    in_bit = 1'b1;
    in_16  = 16'hABCD;
    in_32  = 32'h12345678;
    in_64  = 64'hABCDEF0123456789;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_rd_en", bus.arr_rd_en, 0);
    chk("rst_addr", bus.arr_addr, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Reference frame, sink always ready
    set_reference();
    ready_mode = 0;
    build_expected();
    start_frame();
    check_frame("ref");
    if (rx_data.size() == 27) chk("ref_csum_cb", rx_data[26], 8'hCB);

    // All-zero inputs and array
    in_bit = 1'b0; in_16 = '0; in_32 = '0; in_64 = '0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    build_expected();
    start_frame();
    check_frame("zero");
    if (rx_data.size() == 27) chk("zero_csum_a5", rx_data[26], 8'hA5);

    // Backpressure: toggling ready plus a 5-cycle stall on byte 3
    set_reference();
    ready_mode = 3;
    build_expected();
    start_frame();
    check_frame("bp");
    ready_mode = 0;

    // Capture isolation: in_32 changes right after the request
    set_reference();
    build_expected();
    start_frame();
    in_32 = 32'hFFFFFFFF;
    check_frame("iso");
    if (rx_data.size() == 27) chk("iso_csum_cb", rx_data[26], 8'hCB);
    chk("overrun_clear", overrun, 0);

    // Request during byte 10: one frame only, overrun sticky
    set_reference();
    build_expected();
    start_frame();
    wait_rx("ovr_mid", 10);
    @(posedge clk); #1; snap_req = 1'b1;
    @(posedge clk); #1; snap_req = 1'b0;
    check_frame("ovr");
    chk("ovr_flag", overrun, 1);
    repeat (30) @(posedge clk);
    #1;
    chk("ovr_single_frame", rx_data.size(), 27);
    chk("ovr_idle", busy, 0);
    in_16 = 16'h5A5A;
    build_expected();
    start_frame();
    check_frame("ovr2");
    chk("ovr_sticky", overrun, 1);

    // Randomized frames with random ready
    ready_mode = 2;
    for (int f = 0; f < 3; f++) begin
      in_bit = 1'($urandom);
      in_16  = 16'($urandom);
      in_32  = $urandom;
      in_64  = {$urandom, $urandom};
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      build_expected();
      start_frame();
      check_frame($sformatf("rnd%0d", f));
    end
    ready_mode = 0;

    // Reset at byte 20 abandons the frame
    set_reference();
    build_expected();
    start_frame();
    wait_rx("rst_mid", 20);
    reset = 1'b1;
    #1;
    chk("rstmid_valid", bus.out_valid, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_overrun", overrun, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_rx();
    repeat (20) @(posedge clk);
    #1;
    chk("rstmid_no_bytes", rx_data.size(), 0);
    start_frame();
    check_frame("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/var_snapshot_reader.md
Name: var_snapshot_reader

Overview:
- Reader side of the mixed-width variable store: on request, captures a 1-bit, 16-bit, 32-bit and 64-bit variable plus an ARRAY_DEPTH-entry byte array.
- Streams the captured state out as a framed byte stream with valid/ready handshake.
- Frame: header, scalars MSB-first, array entries in ascending index, then an XOR checksum.
- Sits between the variable storage and a debug/trace byte sink.

Parameters:
- ARRAY_DEPTH, 10: number of 8-bit array entries read per frame (legal range 1..16).
- HEADER, 8'hA5: first byte of every frame.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- snap_req  input  1  one-cycle request to capture and send a frame.
- in_bit  input  1  single-bit variable.
- in_16  input  16  two-byte variable.
- in_32  input  32  four-byte variable.
- in_64  input  64  eight-byte variable.
- arr_rd_en  output  1  array read strobe.
- arr_addr  output  4  array read address.
- arr_rdata  input  8  array read data, valid exactly 1 cycle after arr_rd_en.
- out_data  output  8  stream byte.
- out_valid  output  1  out_data valid.
- out_ready  input  1  sink accepts when out_valid && out_ready.
- out_last  output  1  high with the checksum byte only.
- busy  output  1  frame in progress.
- overrun  output  1  sticky; set when snap_req arrives while busy.

Behaviour:
- Reset (async, immediate): out_valid=0, out_last=0, out_data=0, busy=0, overrun=0, arr_rd_en=0, arr_addr=0; FSM=IDLE; checksum cleared. Reset mid-frame abandons the frame; no partial bytes follow reset release.
- Frame length = 17 + ARRAY_DEPTH bytes (27 at default), in order:
  - HEADER
  - {7'b0,in_bit}
  - in_16 (2 bytes, MSB first)
  - in_32 (4 bytes, MSB first)
  - in_64 (8 bytes, MSB first)
  - arr[0..ARRAY_DEPTH-1]
  - checksum = XOR of all preceding bytes of the frame, header included.
- Capture: in_bit/in_16/in_32/in_64 are registered on the cycle snap_req is accepted in IDLE. Later input changes do not affect the frame.
- FSM states and transitions:
  - IDLE: snap_req -> HDR; busy=1 from the next cycle.
  - HDR: out_valid=1, out_data=HEADER; on handshake -> SCALAR.
  - SCALAR: byte index 0..14 presents the captured bytes; on handshake at index 14 -> ARR_RD.
  - ARR_RD: arr_rd_en=1 for exactly one cycle with arr_addr=k, out_valid=0 -> ARR_SEND.
  - ARR_SEND: registers arr_rdata, presents it with out_valid=1; on handshake, k<ARRAY_DEPTH-1 -> ARR_RD (k+1), else -> CSUM.
  - CSUM: out_data=checksum, out_last=1; on handshake -> IDLE; busy=0 the next cycle.
- Handshake: while out_valid=1 and out_ready=0, out_data and out_last are held stable. out_valid never drops without a handshake (except on reset). Back-to-back transfers at one byte/cycle within HDR/SCALAR; each array byte costs at least 2 cycles.
- Checksum accumulates on each handshake, not on presentation. It resets to 0 on entry to HDR.
- snap_req in any non-IDLE state: ignored, overrun<=1. Cleared only by reset.
- snap_req on the same cycle the CSUM handshake completes: ignored and sets overrun (still busy). It is accepted in IDLE on a later cycle.
- arr_addr holds its last value when arr_rd_en=0. It wraps nowhere; the maximum value is ARRAY_DEPTH-1.

Test Plan:
- Reference frame: in_bit=1, in_16=16'hABCD, in_32=32'h12345678, in_64=64'hABCDEF0123456789, arr[i]=i, out_ready=1, snap_req pulse -> 27 bytes A5,01,AB,CD,12,34,56,78,AB,CD,EF,01,23,45,67,89,00..09,CB; out_last only on CB; busy drops after.
- All-zero inputs/array -> A5, 25×00, checksum A5; exactly 10 arr_rd_en pulses with addr 0..9.
- Backpressure: out_ready toggled 1/0 each cycle plus a 5-cycle stall on byte 3 -> identical byte sequence to the first test; out_data stable throughout the stall.
- Capture isolation: change in_32 to 32'hFFFFFFFF one cycle after snap_req -> frame still carries 12,34,56,78, checksum CB.
- snap_req during frame (byte 10) -> overrun=1, single frame only; new snap_req after busy=0 -> second correct frame, overrun stays 1.
- Reset asserted at byte 20 -> out_valid=0 immediately, busy=0; after release and snap_req -> complete 27-byte frame starting with A5.
